// File: rtl/negate_rr_arbiter.sv
// negate_rr_arbiter: round-robin share of one ready/valid negate unit among N requesters.
// Define ARB_STATS_EN to add per-requester saturating grant counters on grant_count.
module negate_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 32,
    parameter int DEPTH = 4,
    localparam int IW = $clog2(N),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N*W-1:0]  req_data,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    output logic [N*W-1:0]  resp_data,
    output logic [N-1:0]    resp_valid,
    input  logic [N-1:0]    resp_ready,
    output logic [W-1:0]    unit_in,
    output logic            unit_in_valid,
    input  logic            unit_in_ready,
    input  logic [W-1:0]    unit_out,
    input  logic            unit_out_valid,
    output logic            unit_out_ready,
    output logic [CW-1:0]   inflight
`ifdef ARB_STATS_EN
    ,
    output logic [N*16-1:0] grant_count
`endif
);
    logic [IW-1:0] rr_ptr, g, off, head;
    logic [IW:0] gsum;
    logic [2*N-1:0] rot;
    logic [IW-1:0] tags [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic any_valid, full, empty, push, pop;

    assign any_valid = |req_valid;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head = tags[rd_ptr];
    // rotate so bit 0 is the highest-priority requester, then find the first set bit
    assign rot = {req_valid, req_valid} >> rr_ptr;

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
        gsum = {1'b0, rr_ptr} + {1'b0, off};
        g = gsum >= (IW+1)'(N) ? IW'(gsum - (IW+1)'(N)) : gsum[IW-1:0];
    end

    always_comb begin
        unit_in = '0;
        req_ready = '0;
        resp_valid = '0;
        for (int k = 0; k < N; k++) begin
            unit_in = g == IW'(k) ? req_data[k*W +: W] : unit_in;
            req_ready[k] = reset_n && any_valid && unit_in_ready && !full && g == IW'(k);
            resp_valid[k] = reset_n && unit_out_valid && !empty && head == IW'(k);
        end
    end

    // full blocks issue even if a pop lands in the same cycle
    assign unit_in_valid = reset_n && any_valid && !full;
    assign unit_out_ready = reset_n && !empty && resp_ready[head];
    assign resp_data = {N{unit_out}};
    assign push = unit_in_valid && unit_in_ready;
    assign pop = unit_out_valid && unit_out_ready;
    assign inflight = count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                rr_ptr <= g == IW'(N - 1) ? '0 : g + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) tags[wr_ptr] <= g;
    end

`ifdef ARB_STATS_EN
    logic [15:0] cnt [N];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++)
                if (push && g == IW'(k) && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 1'b1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int k = 0; k < N; k++) grant_count[k*16 +: 16] = cnt[k];
    end
`endif
endmodule

// File: tb/tb_negate_rr_arbiter.sv
// tb_negate_rr_arbiter: directed bench for negate_rr_arbiter with a behavioural one-cycle negate unit.
`timescale 1ns/1ps
module tb_negate_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] resp_data;
    logic [N-1:0] resp_valid;
    logic [N-1:0] resp_ready = '0;
    logic [W-1:0] unit_in;
    logic unit_in_valid;
    logic unit_in_ready = 1'b1;
    logic [W-1:0] unit_out;
    logic unit_out_valid;
    logic unit_out_ready;
    logic [2:0] inflight;
`ifdef ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    int n_chk = 0;
    int n_fail = 0;

    negate_rr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_data(req_data),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .resp_data(resp_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .unit_in(unit_in),
        .unit_in_valid(unit_in_valid),
        .unit_in_ready(unit_in_ready),
        .unit_out(unit_out),
        .unit_out_valid(unit_out_valid),
        .unit_out_ready(unit_out_ready),
        .inflight(inflight)
`ifdef ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 clock = ~clock;

    // negate unit model: one cycle latency, in order
    logic [W-1:0] q [$];
    logic in_hs = 1'b0, out_hs = 1'b0;
    logic [W-1:0] in_val = '0;
    int qn = 0;
    logic [W-1:0] q_head = '0;
    logic out_en = 1'b1;

    always @(negedge clock) begin
        in_hs <= unit_in_valid && unit_in_ready;
        out_hs <= unit_out_valid && unit_out_ready;
        in_val <= unit_in;
    end

    always @(posedge clock) begin
        #1;
        if (!reset_n) q.delete();
        else begin
            if (out_hs && q.size() > 0) void'(q.pop_front());
            if (in_hs) q.push_back(-in_val);
        end
        qn <= q.size();
        q_head <= q.size() > 0 ? q[0] : '0;
    end

    assign unit_out = q_head;
    assign unit_out_valid = out_en && qn != 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // reset: outputs forced low even with requests pending
        req_valid = 4'hF;
        resp_ready = 4'hF;
        tick();
        #1;
        check("rst_inflight", 32'(inflight), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_in_valid", 32'(unit_in_valid), 0);
        check("rst_out_ready", 32'(unit_out_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        req_valid = '0;
        reset_n = 1'b1;
        tick();

        // single requester 1
        req_data[1*W +: W] = 32'd420;
        req_valid = 4'b0010;
        #1;
        check("single_in_valid", 32'(unit_in_valid), 1);
        check("single_unit_in", unit_in, 32'd420);
        check("single_req_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        #1;
        check("single_inflight1", 32'(inflight), 1);
        check("single_resp_valid", 32'(resp_valid), 32'b0010);
        check("single_resp_data", resp_data[1*W +: W], 32'hFFFFFE5C);
        tick();
        #1;
        check("single_inflight0", 32'(inflight), 0);
        check("single_resp_idle", 32'(resp_valid), 0);

        // round-robin fairness from a fresh rr pointer
        do_reset();
        for (int k = 0; k < N; k++) req_data[k*W +: W] = 32'(100 + k);
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_unit_in", unit_in, 32'(100 + i % 4));
            check("rr_req_ready", 32'(req_ready), 32'(1 << (i % 4)));
            if (i > 0) begin
                check("rr_resp_valid", 32'(resp_valid), 32'(1 << ((i - 1) % 4)));
                check("rr_resp_data", unit_out, 32'(-(100 + (i - 1) % 4)));
            end
            tick();
        end
        req_valid = '0;
        #1;
        check("rr_last_resp", 32'(resp_valid), 32'b1000);
        check("rr_last_data", resp_data[3*W +: W], 32'(-103));
        tick();
        #1;
        check("rr_drained", 32'(inflight), 0);

        // full: results held back by resp_ready
        do_reset();
        for (int k = 0; k < N; k++) req_data[k*W +: W] = 32'(10 + k);
        resp_ready = '0;
        req_valid = 4'hF;
        repeat (4) tick();
        #1;
        check("full_inflight", 32'(inflight), 4);
        check("full_in_valid", 32'(unit_in_valid), 0);
        check("full_req_ready", 32'(req_ready), 0);
        check("full_head_resp", 32'(resp_valid), 32'b0001);
        resp_ready = 4'hF;
        #1;
        check("full_pop_ready", 32'(unit_out_ready), 1);
        check("full_no_bypass", 32'(unit_in_valid), 0);
        tick();
        #1;
        check("full_after_pop", 32'(inflight), 3);
        check("full_push_next", 32'(req_ready), 32'b0001);
        check("full_next_resp", 32'(resp_valid), 32'b0010);
        check("full_next_data", unit_out, 32'(-11));
        tick();
        req_valid = '0;
        #1;
        check("full_pushpop", 32'(inflight), 3);
        repeat (3) tick();
        #1;
        check("full_drained", 32'(inflight), 0);

        // response backpressure on requester 2
        do_reset();
        req_data[2*W +: W] = 32'hFFFFFFBB;
        resp_ready = 4'b1011;
        req_valid = 4'b0100;
        #1;
        check("bp_req_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_out_ready", 32'(unit_out_ready), 0);
            check("bp_resp_valid", 32'(resp_valid), 32'b0100);
            check("bp_inflight", 32'(inflight), 1);
            tick();
        end
        resp_ready = 4'hF;
        #1;
        check("bp_release", 32'(unit_out_ready), 1);
        check("bp_only_req2", 32'(resp_valid), 32'b0100);
        check("bp_data", resp_data[2*W +: W], 32'd69);
        tick();
        #1;
        check("bp_drained", 32'(inflight), 0);

        // async reset mid-stream
        do_reset();
        for (int k = 0; k < N; k++) req_data[k*W +: W] = 32'(200 + k);
        resp_ready = '0;
        req_valid = 4'hF;
        repeat (3) tick();
        #1;
        check("ar_inflight3", 32'(inflight), 3);
        check("ar_grant3", 32'(req_ready), 32'b1000);
        reset_n = 1'b0;
        #1;
        check("ar_inflight0", 32'(inflight), 0);
        check("ar_req_ready", 32'(req_ready), 0);
        check("ar_in_valid", 32'(unit_in_valid), 0);
        check("ar_out_ready", 32'(unit_out_ready), 0);
        check("ar_resp_valid", 32'(resp_valid), 0);
        tick();
        reset_n = 1'b1;
        resp_ready = 4'hF;
        #1;
        check("ar_first_grant", 32'(req_ready), 32'b0001);
        check("ar_first_data", unit_in, 32'd200);
        check("ar_no_resp", 32'(resp_valid), 0);
        req_valid = '0;
        tick();
        tick();

`ifdef ARB_STATS_EN
        // grant counters: 2,1,0 for requesters 0..2, requester 3 saturates
        do_reset();
        resp_ready = 4'hF;
        req_valid = 4'b0011;
        repeat (2) tick();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1000;
        repeat (70000) tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        check("stats_req0", 32'(grant_count[0 +: 16]), 2);
        check("stats_req1", 32'(grant_count[16 +: 16]), 1);
        check("stats_req2", 32'(grant_count[32 +: 16]), 0);
        check("stats_req3", 32'(grant_count[48 +: 16]), 65535);
        check("stats_drained", 32'(inflight), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
